count_job_scheduler: RTL and testbench
======================================

// Module: count_job_scheduler
// PURPOSE
//  Shares one CNT_W-bit run counter among NUM_REQ requesters.
//  Each requester asks for a count job of programmable length. A round-robin arbiter
//  grants one job at a time, sequences the counter through 0..len and pulses done to
//  the granted requester. Sits between client FSMs and the shared counting resource.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..16)
//  CNT_W    4  counter / job-length width in bits
// PORTS
//  clk      in   1                  single clock; all state on rising edge
//  rst_n    in   1                  reset, asynchronous, active-low
//  req      in   NUM_REQ            per-requester job request, level
//  len      in   NUM_REQ*CNT_W      job length per requester; slice i = len[i*CNT_W +: CNT_W]
//  abort    in   1                  terminate current job, no done
//  grant    out  NUM_REQ            one-hot owner of the counter, registered
//  cur_id   out  $clog2(NUM_REQ)    index of current/last owner, registered
//  busy     out  1                  high while state==RUN, registered
//  count    out  CNT_W              shared counter value, registered
//  done     out  NUM_REQ            Mealy completion pulse, combinational
// BEHAVIOUR
//  Reset (async, rst_n=0): outputs clear immediately, with no clock edge needed.
//   - state=IDLE, grant=0, busy=0, cur_id=0, count=0, target=0, done=0.
//   - Last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
//  States: IDLE, RUN (2-bit encoding). Unused encodings -> IDLE.
//  IDLE, no req: hold. IDLE with |req and !abort, on the clock edge:
//   - id = first set req bit searching from last+1 upward, wrapping.
//   - grant <= onehot(id); cur_id <= id; last <= id.
//   - target <= len[id] (latched; later len changes ignored).
//   - count <= 0; state <= RUN.
//  RUN:
//   - count increments by 1 each cycle while count != target.
//   - done[cur_id] = (state==RUN && count==target && !abort); other done bits 0.
//   - On the edge after count==target: state <= IDLE, grant <= 0.
//   - count holds its final value; no wrap, because count never exceeds target.
//  Timing: job length L runs L+1 RUN cycles. len=0 gives done in the first RUN cycle.
//  Latency: req sampled on edge E -> grant high from E; done in the cycle starting E+L.
//  Gap: exactly one IDLE cycle after every job, even if requests are pending.
//  Requester rules:
//   - Must drop req during the cycle its done is high.
//   - If req is still high in IDLE, it is a new request, arbitrated round-robin.
//  req deassert during RUN: ignored; the job completes and done still pulses.
//  abort in RUN: next edge -> IDLE, grant=0, count holds, no done.
//   - last is already updated, so the aborted requester loses its turn.
//  abort in IDLE: blocks the grant that cycle.
//  abort and count==target in the same cycle: abort wins, done stays 0.
//  Reset mid-RUN: job discarded; no done ever appears for it.
// TESTING
//  1) req=0010, len[1]=3, held until done
//     -> grant=0010 for 4 cycles, count 0,1,2,3; done[1]=1 only when count=3;
//        then 1 cycle grant=0.
//  2) req=1111, all len=0
//     -> grants 0001,0010,0100,1000, each 1 RUN + 1 IDLE cycle; done pulse per requester.
//  3) req0 and req2 held high, len=1
//     -> grant order 0,2,0,2; each run 2 cycles; never two grants together.
//  4) req3 len=5, abort at count=2
//     -> grant drops next edge, done stays 0; pending req0 granted after 1 IDLE cycle.
//  5) rst_n low mid-RUN between clock edges
//     -> grant/busy/count zero immediately; after release, req=0101 grants 0 first.
//  6) len[1] changed 3->9 during RUN
//     -> done still at count=3; 9 takes effect only on the next grant.

Source files
------------

// File: rtl/count_job_scheduler.sv
// count_job_scheduler
//   Lets NUM_REQ requesters share one CNT_W-bit run counter. A round-robin
//   arbiter hands the counter to one requester at a time. The counter then
//   steps through 0..len for that requester, and a done pulse is returned to it.
//
// Ports
//   clk     in   clock, all state on rising edge
//   rst_n   in   asynchronous active-low reset
//   req     in   [NUM_REQ]        per-requester job request (level)
//   len     in   [NUM_REQ*CNT_W]  job length, slice i = len[i*CNT_W +: CNT_W]
//   abort   in   ends the current job with no done; in IDLE, blocks the grant
//   grant   out  [NUM_REQ]        one-hot owner of the counter (registered)
//   cur_id  out  [clog2(NUM_REQ)] index of the current/last owner (registered)
//   busy    out  high while a job is running (registered)
//   count   out  [CNT_W]          shared counter (registered)
//   done    out  [NUM_REQ]        completion pulse to the owner (combinational)
module count_job_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CNT_W-1:0]   len,
    input  logic                       abort,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] cur_id,
    output logic                       busy,
    output logic [CNT_W-1:0]           count,
    output logic [NUM_REQ-1:0]         done
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_t;

    state_t                         state, state_nxt;
    logic   [ID_W-1:0]              last;
    logic   [CNT_W-1:0]             target;
    logic   [NUM_REQ-1:0][CNT_W-1:0] len_a;
    logic                           pick_vld;
    logic   [ID_W-1:0]              pick_id;
    logic   [ID_W:0]                srch;
    logic                           start;
    logic                           at_tgt;
    logic                           fin;

    assign len_a  = len;
    assign at_tgt = (count == target);
    assign fin    = (state == RUN) && at_tgt && !abort;

    // Round-robin search: start one past the last owner and wrap. The
    // search index is one bit wider so that last+i does not overflow before
    // the wrap.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        srch     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            srch = {1'b0, last} + (ID_W+1)'(i);
            if (srch >= (ID_W+1)'(NUM_REQ))
                srch = srch - (ID_W+1)'(NUM_REQ);
            if (!pick_vld && req[srch[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = srch[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: if (pick_vld && !abort) begin
                state_nxt = RUN;
                start     = 1'b1;
            end
            RUN:  if (abort || at_tgt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The job parameters are latched at grant time. A later change to len
    // only affects the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant  <= '0;
            cur_id <= '0;
            last   <= ID_W'(NUM_REQ-1);
            target <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            if (start) begin
                grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
                cur_id <= pick_id;
                last   <= pick_id;
                target <= len_a[pick_id];
                count  <= '0;
            end else if (state == RUN) begin
                // The count holds on abort or at target, so it never wraps.
                if (state_nxt == IDLE) grant <= '0;
                else                   count <= count + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_done
        assign done[g] = fin && (cur_id == ID_W'(g));
    end

endmodule

// File: tb/tb_count_job_scheduler.sv
module tb_count_job_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] len = '0;
    logic        abort = 1'b0;
    logic [3:0]  grant;
    logic [1:0]  cur_id;
    logic        busy;
    logic [3:0]  count;
    logic [3:0]  done;

    int errors = 0;
    int checks = 0;

    count_job_scheduler #(.NUM_REQ(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .len(len), .abort(abort),
        .grant(grant), .cur_id(cur_id), .busy(busy), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    // rsb: apply reset before this vector. The inputs are driven just after a
    // rising edge, and the expected outputs are checked at the following
    // falling edge.
    typedef struct {
        logic        rsb;
        logic [3:0]  req;
        logic [15:0] len;
        logic        abort;
        logic [3:0]  g;
        logic [1:0]  cur;
        logic        b;
        logic [3:0]  c;
        logic [3:0]  d;
    } vec_t;

    vec_t tab[$];

    function automatic void v(logic rsb, logic [3:0] rq, logic [15:0] ln, logic ab,
                              logic [3:0] g, logic [1:0] cur, logic b,
                              logic [3:0] c, logic [3:0] d);
        vec_t e;
        e.rsb = rsb; e.req = rq; e.len = ln; e.abort = ab;
        e.g = g; e.cur = cur; e.b = b; e.c = c; e.d = d;
        tab.push_back(e);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset(int idx);
        @(posedge clk); #1;
        rst_n = 1'b0; req = '0; abort = 1'b0;
        #1;
        chk("rst_grant", idx, 32'(grant), 0);
        chk("rst_busy",  idx, 32'(busy),  0);
        chk("rst_count", idx, 32'(count), 0);
        chk("rst_cur",   idx, 32'(cur_id), 0);
        chk("rst_done",  idx, 32'(done),  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // 1) Single job, len[1]=3.
        v(1, 4'h2, 16'h0030, 0, 4'h0, 0, 0, 0, 4'h0);
        v(0, 4'h2, 16'h0030, 0, 4'h2, 1, 1, 0, 4'h0);
        v(0, 4'h2, 16'h0030, 0, 4'h2, 1, 1, 1, 4'h0);
        v(0, 4'h2, 16'h0030, 0, 4'h2, 1, 1, 2, 4'h0);
        v(0, 4'h0, 16'h0030, 0, 4'h2, 1, 1, 3, 4'h2);
        v(0, 4'h0, 16'h0030, 0, 4'h0, 1, 0, 3, 4'h0);
        // 2) Everyone requests with len=0. Each requester drops req in its done cycle.
        v(1, 4'hF, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0);
        v(0, 4'hE, 16'h0000, 0, 4'h1, 0, 1, 0, 4'h1);
        v(0, 4'hE, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0);
        v(0, 4'hC, 16'h0000, 0, 4'h2, 1, 1, 0, 4'h2);
        v(0, 4'hC, 16'h0000, 0, 4'h0, 1, 0, 0, 4'h0);
        v(0, 4'h8, 16'h0000, 0, 4'h4, 2, 1, 0, 4'h4);
        v(0, 4'h8, 16'h0000, 0, 4'h0, 2, 0, 0, 4'h0);
        v(0, 4'h0, 16'h0000, 0, 4'h8, 3, 1, 0, 4'h8);
        v(0, 4'h0, 16'h0000, 0, 4'h0, 3, 0, 0, 4'h0);
        // 3) Requesters 0 and 2 hold req high, len=1. Grants alternate 0,2,0,2.
        v(1, 4'h5, 16'h0101, 0, 4'h0, 0, 0, 0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            v(0, 4'h5, 16'h0101, 0, 4'h1, 0, 1, 0, 4'h0);
            v(0, 4'h5, 16'h0101, 0, 4'h1, 0, 1, 1, 4'h1);
            v(0, 4'h5, 16'h0101, 0, 4'h0, 0, 0, 1, 4'h0);
            v(0, 4'h5, 16'h0101, 0, 4'h4, 2, 1, 0, 4'h0);
            v(0, 4'h5, 16'h0101, 0, 4'h4, 2, 1, 1, 4'h4);
            v(0, 4'h5, 16'h0101, 0, 4'h0, 2, 0, 1, 4'h0);
        end
        // 4) Requester 3 job (len 5) is aborted at count=2. Pending requester 0 runs next.
        v(1, 4'h8, 16'h5002, 0, 4'h0, 0, 0, 0, 4'h0);
        v(0, 4'h9, 16'h5002, 0, 4'h8, 3, 1, 0, 4'h0);
        v(0, 4'h9, 16'h5002, 0, 4'h8, 3, 1, 1, 4'h0);
        v(0, 4'h9, 16'h5002, 1, 4'h8, 3, 1, 2, 4'h0);
        v(0, 4'h1, 16'h5002, 0, 4'h0, 3, 0, 2, 4'h0);
        v(0, 4'h1, 16'h5002, 0, 4'h1, 0, 1, 0, 4'h0);
        v(0, 4'h1, 16'h5002, 0, 4'h1, 0, 1, 1, 4'h0);
        v(0, 4'h0, 16'h5002, 0, 4'h1, 0, 1, 2, 4'h1);
        v(0, 4'h0, 16'h5002, 0, 4'h0, 0, 0, 2, 4'h0);
        // Abort arrives in the same cycle that count reaches target: no done.
        v(1, 4'h1, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0);
        v(0, 4'h1, 16'h0000, 1, 4'h1, 0, 1, 0, 4'h0);
        v(0, 4'h0, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0);
        // Abort while IDLE holds off the grant for that cycle.
        v(1, 4'h2, 16'h0000, 1, 4'h0, 0, 0, 0, 4'h0);
        v(0, 4'h2, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0);
        v(0, 4'h0, 16'h0000, 0, 4'h2, 1, 1, 0, 4'h2);
        v(0, 4'h0, 16'h0000, 0, 4'h0, 1, 0, 0, 4'h0);
        // 6) len[1] changes 3->9 during RUN. The new value applies only to the next grant.
        v(1, 4'h2, 16'h0030, 0, 4'h0, 0, 0, 0, 4'h0);
        v(0, 4'h2, 16'h0090, 0, 4'h2, 1, 1, 0, 4'h0);
        v(0, 4'h2, 16'h0090, 0, 4'h2, 1, 1, 1, 4'h0);
        v(0, 4'h2, 16'h0090, 0, 4'h2, 1, 1, 2, 4'h0);
        v(0, 4'h0, 16'h0090, 0, 4'h2, 1, 1, 3, 4'h2);
        v(0, 4'h0, 16'h0090, 0, 4'h0, 1, 0, 3, 4'h0);
        v(0, 4'h2, 16'h0090, 0, 4'h0, 1, 0, 3, 4'h0);
        for (int k = 0; k < 9; k++)
            v(0, 4'h2, 16'h0090, 0, 4'h2, 1, 1, 4'(k), 4'h0);
        v(0, 4'h0, 16'h0090, 0, 4'h2, 1, 1, 9, 4'h2);
        v(0, 4'h0, 16'h0090, 0, 4'h0, 1, 0, 9, 4'h0);

        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].rsb) do_reset(i);
            else begin @(posedge clk); #1; end
            req = tab[i].req; len = tab[i].len; abort = tab[i].abort;
            @(negedge clk);
            chk("grant", i, 32'(grant),  32'(tab[i].g));
            chk("cur_id", i, 32'(cur_id), 32'(tab[i].cur));
            chk("busy",  i, 32'(busy),   32'(tab[i].b));
            chk("count", i, 32'(count),  32'(tab[i].c));
            chk("done",  i, 32'(done),   32'(tab[i].d));
        end

        // 5) Reset asserted between edges in the middle of a job.
        do_reset(1000);
        req = 4'h2; len = 16'h0030;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy",  1001, 32'(busy),  1);
        chk("mid_count", 1001, 32'(count), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_grant", 1002, 32'(grant), 0);
        chk("async_busy",  1002, 32'(busy),  0);
        chk("async_count", 1002, 32'(count), 0);
        chk("async_done",  1002, 32'(done),  0);
        req = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1; req = 4'h5; len = 16'h0000;
        @(negedge clk);
        chk("post_idle_grant", 1003, 32'(grant), 0);
        @(posedge clk); #1;
        chk("post_grant",  1004, 32'(grant),  1);
        chk("post_cur",    1004, 32'(cur_id), 0);
        chk("post_done",   1004, 32'(done),   1);
        req = 4'h0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
